// File: rtl/instr_loader_if.sv
// Loader bus bundle: boot request, instruction stream handshake and the
// instruction-memory / PC control outputs driven by the loader.
//
// Handshake: a word on in_data is transferred on a rising clk edge where
// in_valid and in_ready are both high; in_valid may be raised at any time
// and in_data must be held stable while in_valid is high and in_ready low.
interface instr_loader_if #(
  parameter int ADDR_W = 8
);
  logic              start;
  logic [ADDR_W:0]   prog_len;
  logic              in_valid;
  logic [31:0]       in_data;
  logic              in_ready;
  logic [31:0]       mem_addr;
  logic [31:0]       mem_wdata;
  logic              mem_write;
  logic              mem_read;
  logic              pc_reset;
  logic              pc_write;
  logic              initializing;
  logic [ADDR_W:0]   words_loaded;
  logic              done;
  logic              error;

  modport master (
    output start, prog_len, in_valid, in_data,
    input  in_ready, mem_addr, mem_wdata, mem_write, mem_read,
           pc_reset, pc_write, initializing, words_loaded, done, error
  );

  modport slave (
    input  start, prog_len, in_valid, in_data,
    output in_ready, mem_addr, mem_wdata, mem_write, mem_read,
           pc_reset, pc_write, initializing, words_loaded, done, error
  );
endinterface

// File: rtl/instr_loader.sv
// Boot-time program loader: streams instruction words into consecutive
// instruction-memory words, then releases the PC / pipeline.
module instr_loader #(
  parameter int          ADDR_W    = 8,
  parameter int          MAX_WORDS = 256,
  parameter logic [31:0] BASE_ADDR = 32'd0
) (
  input  logic           clk,
  input  logic           reset_n,
  instr_loader_if.slave  bus,
  output logic [2:0]     dbg_state_o
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_DRAIN = 3'd2,
    S_RUN   = 3'd3,
    S_ERR   = 3'd4
  } state_e;

  localparam logic [ADDR_W:0] MAX_LEN = (ADDR_W+1)'(MAX_WORDS);

  state_e          state_q, state_d;
  logic [ADDR_W:0] len_q, len_d;
  logic [ADDR_W:0] words_q, words_d;
  logic [ADDR_W:0] words_inc;
  logic [31:0]     mem_addr_q, mem_addr_d;
  logic [31:0]     mem_wdata_q, mem_wdata_d;
  logic            mem_write_q, mem_write_d;
  logic            mem_read_q, mem_read_d;
  logic            pc_reset_q, pc_reset_d;
  logic            pc_write_q, pc_write_d;
  logic            init_q, init_d;
  logic            done_q, done_d;
  logic            error_q, error_d;
  logic            in_ready;
  logic            hs;

  assign in_ready  = (state_q == S_LOAD);
  assign hs        = bus.in_valid & in_ready;
  assign words_inc = words_q + 1'b1;

  // State and registered outputs; reset restores the pre-boot condition and
  // drops any write still pending from the last accepted word.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      len_q       <= '0;
      words_q     <= '0;
      mem_addr_q  <= BASE_ADDR;
      mem_wdata_q <= '0;
      mem_write_q <= 1'b0;
      mem_read_q  <= 1'b0;
      pc_reset_q  <= 1'b1;
      pc_write_q  <= 1'b0;
      init_q      <= 1'b1;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      words_q     <= words_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_write_q <= mem_write_d;
      mem_read_q  <= mem_read_d;
      pc_reset_q  <= pc_reset_d;
      pc_write_q  <= pc_write_d;
      init_q      <= init_d;
      done_q      <= done_d;
      error_q     <= error_d;
    end
  end

  // Next state: RUN and ERR are absorbing, only reset leaves them.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          if (bus.prog_len == '0)          state_d = S_RUN;
          else if (bus.prog_len > MAX_LEN) state_d = S_ERR;
          else                             state_d = S_LOAD;
        end
      end
      S_LOAD:  if (hs && (words_inc == len_q)) state_d = S_DRAIN;
      S_DRAIN: state_d = S_RUN;
      S_RUN:   state_d = S_RUN;
      S_ERR:   state_d = S_ERR;
      default: state_d = S_IDLE;
    endcase
  end

  // Next values of registered outputs; mem_write is a one-cycle pulse per word.
  always_comb begin
    len_d       = len_q;
    words_d     = words_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_write_d = 1'b0;
    mem_read_d  = mem_read_q;
    pc_reset_d  = pc_reset_q;
    pc_write_d  = pc_write_q;
    init_d      = init_q;
    done_d      = done_q;
    error_d     = error_q;

    if ((state_q == S_IDLE) && (state_d == S_LOAD)) begin
      len_d = bus.prog_len;
    end

    if (hs) begin
      mem_wdata_d = bus.in_data;
      mem_addr_d  = BASE_ADDR + (32'(words_q) << 2);
      mem_write_d = 1'b1;
      words_d     = words_inc;
    end

    if ((state_d == S_RUN) && (state_q != S_RUN)) begin
      pc_reset_d = 1'b0;
      pc_write_d = 1'b1;
      mem_read_d = 1'b1;
      init_d     = 1'b0;
      done_d     = 1'b1;
    end

    if (state_d == S_ERR) begin
      error_d = 1'b1;
    end
  end

  assign bus.in_ready     = in_ready;
  assign bus.mem_addr     = mem_addr_q;
  assign bus.mem_wdata    = mem_wdata_q;
  assign bus.mem_write    = mem_write_q;
  assign bus.mem_read     = mem_read_q;
  assign bus.pc_reset     = pc_reset_q;
  assign bus.pc_write     = pc_write_q;
  assign bus.initializing = init_q;
  assign bus.words_loaded = words_q;
  assign bus.done         = done_q;
  assign bus.error        = error_q;
  assign dbg_state_o      = state_q;

endmodule

// File: doc/instr_loader.md
Name: instr_loader

Overview:
- Boot-time program loader sitting directly upstream of the processor's instruction memory and PC.
- Accepts a stream of 32-bit instruction words over a valid/ready handshake and writes them to consecutive word addresses of instruction memory.
- After the last word is written, it releases the pipeline: PC reset is deasserted, PC write is enabled, memory is switched to read mode and the initializing flag is cleared.
- It replaces testbench-driven loading, so simulation and synthesis boot identically.

Parameters:
- ADDR_W, 8, width of the word counter and the word-index space.
- MAX_WORDS, 256, largest accepted program length in words; must be ≤ 2^ADDR_W.
- BASE_ADDR, 32'd0, byte address of the first instruction.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request to begin loading; sampled in IDLE only.
- prog_len  in  ADDR_W+1  number of words to load; sampled with start.
- in_valid  in  1  in_data is valid.
- in_data  in  32  instruction word.
- in_ready  out  1  loader accepts in_data this cycle.
- mem_addr  out  32  instruction-memory byte address.
- mem_wdata  out  32  instruction-memory write data.
- mem_write  out  1  instruction-memory write enable.
- mem_read  out  1  instruction-memory read enable; asserted once the pipeline is released.
- pc_reset  out  1  holds PC at 0 while high.
- pc_write  out  1  PC write enable.
- initializing  out  1  high until release; selects the loader's mem_addr over the PC at the instruction-memory address mux.
- words_loaded  out  ADDR_W+1  count of words written so far.
- done  out  1  level; program loaded and pipeline released.
- error  out  1  level; prog_len was greater than MAX_WORDS.

Behaviour:
- Reset values (async, on reset_n low):
  - state=IDLE.
  - in_ready=0, mem_write=0, mem_read=0, pc_write=0.
  - pc_reset=1, initializing=1.
  - mem_addr=BASE_ADDR, mem_wdata=0, words_loaded=0, done=0, error=0.
- All outputs are registered except in_ready, which is a decode of state.
- States: IDLE, LOAD, DRAIN, RUN, ERR.
- IDLE:
  - in_ready=0; in_valid is ignored.
  - start with prog_len==0 goes to RUN (empty program release).
  - start with prog_len>MAX_WORDS goes to ERR.
  - Otherwise start latches prog_len into len_q and goes to LOAD.
- LOAD:
  - in_ready=1, sustaining one word per cycle.
  - On an in_valid & in_ready edge:
    - mem_wdata<=in_data.
    - mem_addr<=BASE_ADDR + 4*words_loaded.
    - mem_write<=1 for the next cycle only.
    - words_loaded increments.
  - Write latency: the word is presented to memory one cycle after handshake and committed at the following rising edge.
  - When the accepted word makes words_loaded==len_q, go to DRAIN.
  - Cycles without in_valid insert gaps; mem_write=0 during gaps.
  - start is ignored.
- DRAIN:
  - One cycle; in_ready=0.
  - The final mem_write is active this cycle.
  - Next state is RUN.
- RUN:
  - Entry edge sets pc_reset<=0, pc_write<=1, mem_read<=1, initializing<=0, done<=1.
  - mem_write=0.
  - Absorbing: start and in_valid are ignored; only reset_n leaves RUN.
- ERR:
  - error=1, in_ready=0, pc_reset stays 1.
  - Absorbing until reset_n.
- mem_addr increments by 4 per word and never wraps, because prog_len≤MAX_WORDS≤2^ADDR_W.
- Reset during LOAD or DRAIN:
  - Immediate return to IDLE with reset values.
  - Words already written remain in memory.
  - A pending mem_write is cancelled.
- A word presented in the same cycle as reset_n deassertion is not accepted (the state is IDLE).

Test Plan:
1. Reset, then start with prog_len=7 and back-to-back words 20110005, 20100002, 2012fffd, ac000005, 00009820, 8c080005, 02304882.
   - Writes to addresses 0,4,…,24 with matching data, one per cycle.
   - done rises 2 cycles after the last handshake, with pc_reset=0, pc_write=1, mem_read=1, initializing=0, words_loaded=7.
2. Same program with in_valid low every other cycle.
   - Identical memory contents.
   - mem_write is never asserted in gap cycles.
   - done follows 2 cycles after the 7th handshake.
3. start with prog_len=0.
   - RUN on the next edge with done=1.
   - mem_write never asserted; words_loaded=0.
4. start with prog_len=MAX_WORDS+1.
   - error=1, in_ready stays 0, pc_reset stays 1.
   - A later start is ignored.
5. reset_n pulsed low after 3 of 7 words.
   - All outputs return to reset values asynchronously; words_loaded=0.
   - A new start with prog_len=2 writes addresses 0 and 4 and releases.
6. in_valid=1 held while in IDLE, and start pulsed during LOAD and RUN.
   - No writes in IDLE.
   - Mid-LOAD start does not alter len_q.
   - RUN outputs are unchanged.
